// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, control states, opcode helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_RSB   = 4'd2,
    OP_OR    = 4'd3,
    OP_AND   = 4'd4,
    OP_ANDN  = 4'd5,
    OP_XOR   = 4'd6,
    OP_XNOR  = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_SAR   = 4'd10,
    OP_MUL   = 4'd11,
    OP_RSV12 = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HOLD
  } state_t;

  function automatic logic is_reserved(input op_t op);
    return (op >= OP_RSV12);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation-in / result-out handshake bundle for alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       oper;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             c_out;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, oper, a, b, c_in, out_ready,
    input  in_ready, out_valid, result, result_hi, c_out, zero, neg, ovf, err
  );

  modport slave (
    input  in_valid, oper, a, b, c_in, out_ready,
    output in_ready, out_valid, result, result_hi, c_out, zero, neg, ovf, err
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   w_sum;

  // Add multiplicand into the high word when the current multiplier bit is set.
  always_comb begin
    w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  end

  // Load operands on start, then shift {sum, lo} right once per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_mcand <= i_a;
      r_hi    <= '0;
      r_lo    <= i_b;
    end else if (r_busy) begin
      r_hi  <= w_sum[WIDTH:1];
      r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end

  // The product is exposed as the result of the step in flight, so the
  // caller can capture it on the same edge that retires the final step.
  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == LAST);
  assign o_product = {w_sum, r_lo[WIDTH-1:1]};

endmodule

// File: rtl/alu_seq.sv
// Pipelined ALU with valid/ready on both sides; MUL runs on an iterative unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_t r_state, w_state_nxt;

  op_t              w_op;
  logic [WIDTH-1:0] w_x, w_y;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic             w_big;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH:0]   w_shl, w_shr, w_sar;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_ovf, w_err, w_zero, w_neg;

  logic             w_in_ready, w_accept, w_mul_start, w_load_alu, w_load_mul;
  logic             w_mul_busy, w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_c, r_zero, r_neg, r_ovf, r_err;

  assign w_op = op_t'(bus.oper);

  // Operand selection and shared adder for ADD/SUB/RSB.
  always_comb begin
    w_x = bus.a;
    w_y = bus.b;
    if (w_op == OP_SUB) begin
      w_y = ~bus.b;
    end else if (w_op == OP_RSB) begin
      w_x = bus.b;
      w_y = ~bus.a;
    end
    w_sum     = {1'b0, w_x} + {1'b0, w_y} + (WIDTH+1)'(bus.c_in);
    w_add_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    w_big     = (bus.b >= WIDTH_V);
    w_amt     = bus.b[SHW-1:0];
    // One guard bit on the shifted-out side captures the last bit lost.
    w_shl     = {1'b0, bus.a} << w_amt;
    w_shr     = {bus.a, 1'b0} >> w_amt;
    w_sar     = $signed({bus.a, 1'b0}) >>> w_amt;
  end

  // Single-cycle result and flag generation.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_ovf = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_RSB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_ovf = w_add_ovf;
      end
      OP_OR:   w_res = bus.a | bus.b;
      OP_AND:  w_res = bus.a & bus.b;
      OP_ANDN: w_res = ~bus.a & bus.b;
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_XNOR: w_res = ~(bus.a ^ bus.b);
      OP_SHL:  if (!w_big) {w_c, w_res} = w_shl;
      OP_SHR:  if (!w_big) {w_res, w_c} = w_shr;
      OP_SAR: begin
        if (w_big) w_res = {WIDTH{bus.a[WIDTH-1]}};
        else       {w_res, w_c} = w_sar;
      end
      default: ;
    endcase
    w_err  = is_reserved(w_op);
    w_zero = !w_err && (w_res == '0);
    w_neg  = w_res[WIDTH-1];
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: MUL parks in HOLD until its result is taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_start) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done) w_state_nxt = S_HOLD;
      S_HOLD:  if (r_out_valid && bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and load strobes; in_ready never looks at in_valid.
  always_comb begin
    w_in_ready  = (r_state == S_IDLE) && !w_mul_busy && (!r_out_valid || bus.out_ready);
    w_accept    = bus.in_valid && w_in_ready;
    w_mul_start = w_accept && (w_op == OP_MUL);
    w_load_alu  = w_accept && (w_op != OP_MUL);
    w_load_mul  = (r_state == S_MUL) && w_mul_done;
  end

  // Output registers: hold while stalled, replace on take-and-accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_c         <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_load_alu) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_result_hi <= '0;
      r_c         <= w_c;
      r_zero      <= w_zero;
      r_neg       <= w_neg;
      r_ovf       <= w_ovf;
      r_err       <= w_err;
    end else if (w_load_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_prod[WIDTH-1:0];
      r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
      r_c         <= 1'b0;
      r_zero      <= (w_prod == '0);
      r_neg       <= w_prod[2*WIDTH-1];
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.c_out     = r_c;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
  assign bus.ovf       = r_ovf;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors plus randomized traffic.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic c, z, n, o, e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  bit   rdy_rand = 1'b0;

  task automatic check(input bit ok, input string name, input string info);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, info);
  endtask

  function automatic exp_t mk(input logic [W-1:0] res, input logic [W-1:0] hi,
                              input logic c, input logic z, input logic n,
                              input logic o, input logic e);
    exp_t x;
    x.res = res; x.hi = hi; x.c = c; x.z = z; x.n = n; x.o = o; x.e = e;
    return x;
  endfunction

  function automatic string fmt(input exp_t x);
    return $sformatf("res=%h hi=%h c=%0b z=%0b n=%0b o=%0b e=%0b",
                     x.res, x.hi, x.c, x.z, x.n, x.o, x.e);
  endfunction

  function automatic longint sx(input longint unsigned v);
    if (((v >> (W-1)) & 1) != 0) return longint'(v) - (longint'(1) << W);
    return longint'(v);
  endfunction

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(input int op, input longint unsigned a,
                                 input longint unsigned b, input bit cin);
    longint unsigned mask, r, h, x, y, t;
    longint s;
    bit c, o, e, z, n;
    mask = (longint'(1) << W) - 1;
    r = 0; h = 0; c = 0; o = 0; e = 0;
    case (op)
      0, 1, 2: begin
        x = (op == 2) ? b : a;
        y = (op == 0) ? b : ((op == 1) ? (~b & mask) : (~a & mask));
        t = x + y + cin;
        r = t & mask;
        c = ((t >> W) & 1) != 0;
        s = sx(x) + sx(y) + cin;
        o = (s > ((longint'(1) << (W-1)) - 1)) || (s < -(longint'(1) << (W-1)));
      end
      3: r = a | b;
      4: r = a & b;
      5: r = (~a) & b & mask;
      6: r = a ^ b;
      7: r = ~(a ^ b) & mask;
      8: if (b == 0) r = a;
         else if (b < W) begin r = (a << b) & mask; c = ((a >> (W - b)) & 1) != 0; end
      9: if (b == 0) r = a;
         else if (b < W) begin r = a >> b; c = ((a >> (b - 1)) & 1) != 0; end
      10: if (b == 0) r = a;
          else if (b < W) begin
            r = longint'(sx(a) >>> b) & mask;
            c = ((a >> (b - 1)) & 1) != 0;
          end else r = (((a >> (W-1)) & 1) != 0) ? mask : 0;
      11: begin t = a * b; r = t & mask; h = t >> W; end
      default: e = 1;
    endcase
    z = !e && (r == 0) && (h == 0);
    n = (op == 11) ? (((h >> (W-1)) & 1) != 0) : (((r >> (W-1)) & 1) != 0);
    return mk(r[W-1:0], h[W-1:0], c, z, n, o, e);
  endfunction

  function automatic exp_t cur_out();
    return mk(bus.result, bus.result_hi, bus.c_out, bus.zero, bus.neg, bus.ovf, bus.err);
  endfunction

  // Consumer side: random or constant back-pressure, changed on falling edges.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops on each result take and checks stall stability.
  initial begin
    exp_t prev, cur, ex;
    bit held;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        cur = cur_out();
        if (held) begin
          check(bus.out_valid == 1'b1, "valid_drop", "out_valid fell while stalled, required 1");
          if (bus.out_valid)
            check(cur == prev, "stall_stable",
                  $sformatf("got %s required %s", fmt(cur), fmt(prev)));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check(1'b0, "unexpected_output", $sformatf("got %s with empty scoreboard", fmt(cur)));
          end else begin
            ex = sb.pop_front();
            n_pop++;
            check(cur == ex, "result", $sformatf("got %s required %s", fmt(cur), fmt(ex)));
          end
        end
        held = bus.out_valid && !bus.out_ready;
        prev = cur;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input exp_t e, output bit waited);
    int i;
    waited = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.oper = op;
    bus.a = a;
    bus.b = b;
    bus.c_in = cin;
    #1;
    i = 0;
    while (!bus.in_ready && i < 100) begin
      waited = 1'b1;
      @(negedge clk);
      #1;
      i++;
    end
    if (!bus.in_ready) begin
      check(1'b0, "accept_timeout", "in_ready stayed 0 for 100 cycles, required 1");
    end else begin
      sb.push_back(e);
      n_push++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input exp_t e);
    bit w;
    issue(op, a, b, cin, e, w);
  endtask

  task automatic send_rand(input bit allow_mul, output bit waited);
    int op;
    logic [W-1:0] a, b;
    logic cin;
    do op = $urandom_range(0, 15); while (!allow_mul && op == 11);
    a = W'($urandom);
    b = ($urandom_range(0, 2) == 0) ? W'($urandom) : W'($urandom_range(0, W + 1));
    cin = 1'($urandom_range(0, 1));
    issue(4'(op), a, b, cin, model(op, a, b, cin), waited);
  endtask

  task automatic drain();
    int i;
    rdy_rand = 1'b0;
    i = 0;
    while ((sb.size() != 0 || bus.out_valid) && i < 100) begin
      @(negedge clk);
      #3;
      i++;
    end
    check(sb.size() == 0 && !bus.out_valid, "drain",
          $sformatf("pending=%0d out_valid=%0b, required 0 and 0", sb.size(), bus.out_valid));
  endtask

  // Watchdog so a stuck DUT still terminates the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    int waits, ev, ir;
    logic [W-1:0] ra, rb;
    exp_t z0;
    z0 = '0;
    bus.in_valid = 1'b0;
    bus.oper = '0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check(!bus.out_valid && cur_out() == z0, "reset_outputs",
          $sformatf("got valid=%0b %s required all 0", bus.out_valid, fmt(cur_out())));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(bus.in_ready == 1'b1, "reset_in_ready", $sformatf("got %0b required 1", bus.in_ready));

    // Directed single-cycle vectors.
    send(4'd0, 8'hFF, 8'h01, 1'b0, mk(8'h00, 8'h00, 1, 1, 0, 0, 0));
    @(negedge clk);
    #1;
    check(bus.out_valid == 1'b1, "alu_latency", $sformatf("out_valid=%0b one cycle after accept, required 1", bus.out_valid));
    send(4'd0,  8'h7F, 8'h01, 1'b0, mk(8'h80, 8'h00, 0, 0, 1, 1, 0));
    send(4'd1,  8'h05, 8'h07, 1'b1, mk(8'hFE, 8'h00, 0, 0, 1, 0, 0));
    send(4'd10, 8'h90, 8'h03, 1'b0, mk(8'hF2, 8'h00, 0, 0, 1, 0, 0));
    send(4'd8,  8'h81, 8'h01, 1'b0, mk(8'h02, 8'h00, 1, 0, 0, 0, 0));
    send(4'd9,  8'hA5, 8'h08, 1'b0, mk(8'h00, 8'h00, 0, 1, 0, 0, 0));
    send(4'd13, 8'h5A, 8'h3C, 1'b1, mk(8'h00, 8'h00, 0, 0, 0, 0, 1));
    send(4'd0,  8'h12, 8'h34, 1'b0, mk(8'h46, 8'h00, 0, 0, 0, 0, 0));
    drain();

    // MUL latency and in_ready blocking.
    send(4'd11, 8'hFF, 8'hFF, 1'b0, mk(8'h01, 8'hFE, 0, 0, 1, 0, 0));
    ev = 0;
    ir = 0;
    for (int j = 0; j < W; j++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) ev++;
      if (bus.in_ready) ir++;
    end
    @(negedge clk);
    #1;
    if (bus.in_ready) ir++;
    check(ev == 0, "mul_early", $sformatf("out_valid high in %0d cycles before edge k+8, required 0", ev));
    check(bus.out_valid == 1'b1, "mul_latency", $sformatf("out_valid=%0b after edge k+8, required 1", bus.out_valid));
    check(ir == 0, "mul_in_ready", $sformatf("in_ready high in %0d cycles, required 0", ir));
    drain();

    // Reset part way through a MUL aborts it.
    ra = W'($urandom);
    rb = W'($urandom);
    send(4'd11, ra, rb, 1'b0, model(11, ra, rb, 1'b0));
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check(!bus.out_valid && cur_out() == z0, "reset_in_mul",
          $sformatf("got valid=%0b %s required all 0", bus.out_valid, fmt(cur_out())));
    void'(sb.pop_back());
    n_push--;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    ev = 0;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (bus.out_valid || cur_out() != z0) ev++;
    end
    check(ev == 0, "mul_abort", $sformatf("output activity in %0d cycles after abort, required 0", ev));
    check(bus.in_ready == 1'b1, "ready_after_abort", $sformatf("got %0b required 1", bus.in_ready));
    ra = W'($urandom);
    rb = W'($urandom);
    send(4'd0, ra, rb, 1'b1, model(0, ra, rb, 1'b1));
    drain();

    // Full throughput with out_ready held high.
    waits = 0;
    repeat (8) begin
      send_rand(1'b0, w);
      if (w) waits++;
    end
    check(waits == 0, "throughput", $sformatf("%0d ops waited for in_ready, required 0", waits));
    drain();

    // Random traffic under random back-pressure.
    rdy_rand = 1'b1;
    repeat (16) send_rand(1'b0, w);
    repeat (10) send_rand(1'b1, w);
    drain();

    check(sb.size() == 0 && n_pop == n_push, "no_loss",
          $sformatf("issued=%0d taken=%0d pending=%0d, required equal and 0 pending",
                    n_push, n_pop, sb.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
